// File: rtl/fnd_pkg.sv
// Shared constants for the 3-digit FND scan driver: digit codes and
// active-high segment patterns {g,f,e,d,c,b,a}.
package fnd_pkg;

  localparam int unsigned NUM_DIG  = 3;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned SEG_W    = 7;

  localparam logic [CODE_W-1:0] DIG_BLANK = 4'd10;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;

endpackage

// File: rtl/fnd_if.sv
// Digit-code inputs and FND pin outputs of the scan driver.
interface fnd_if;
  import fnd_pkg::*;

  logic              en;
  logic [CODE_W-1:0] dig_one;
  logic [CODE_W-1:0] dig_ten;
  logic [CODE_W-1:0] dig_hun;
  logic [SEG_W-1:0]  seg;
  logic              dp;
  logic [NUM_DIG-1:0] com;
  logic              frame_done;

  modport master (
    output en, dig_one, dig_ten, dig_hun,
    input  seg, dp, com, frame_done
  );

  modport slave (
    input  en, dig_one, dig_ten, dig_hun,
    output seg, dp, com, frame_done
  );
endinterface

// File: rtl/fnd_seg_decode.sv
// Digit code to active-high 7-segment pattern; 10 blanks, 11-15 show a dash.
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SEG_W-1:0]  o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_code)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      4'd10:   o_seg = SEG_BLANK;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// 3-digit multiplexed FND driver: per-frame digit snapshot, per-slot dead
// time before the common is enabled, and an end-of-frame pulse.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned BLANK_CYC      = 200,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned COM_ACTIVE_LOW = 1
) (
  input logic   clk,
  input logic   rst,
  fnd_if.slave  bus
);

  localparam int unsigned TICK_W = $clog2(SCAN_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_DRIVE = TICK_W'(BLANK_CYC);
  localparam logic [1:0]        IDX_LAST   = 2'(NUM_DIG - 1);

  // XOR masks: applying them to an active-high value gives the pin level
  localparam logic [SEG_W-1:0]   SEG_OFF = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : '0;
  localparam logic               DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIG-1:0] COM_OFF = (COM_ACTIVE_LOW != 0) ? {NUM_DIG{1'b1}} : '0;

  logic [TICK_W-1:0]  r_tick;
  logic [1:0]         r_idx;
  logic [CODE_W-1:0]  r_snap [NUM_DIG];
  logic [SEG_W-1:0]   r_seg;
  logic               r_dp;
  logic [NUM_DIG-1:0] r_com;
  logic               r_frame_done;

  logic [CODE_W-1:0]  w_code;
  logic [SEG_W-1:0]   w_seg_ah;
  logic [NUM_DIG-1:0] w_com_ah;
  logic               w_slot_end;

  always_comb begin
    w_code = DIG_BLANK;
    case (r_idx)
      2'd0:    w_code = r_snap[0];
      2'd1:    w_code = r_snap[1];
      2'd2:    w_code = r_snap[2];
      default: w_code = DIG_BLANK;
    endcase
  end

  assign w_com_ah   = NUM_DIG'(3'b001 << r_idx);
  assign w_slot_end = (r_tick == TICK_LAST);

  fnd_seg_decode u_decode (
    .i_code (w_code),
    .o_seg  (w_seg_ah)
  );

  // Scan counters, frame snapshot and registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick       <= '0;
      r_idx        <= '0;
      r_snap[0]    <= DIG_BLANK;
      r_snap[1]    <= DIG_BLANK;
      r_snap[2]    <= DIG_BLANK;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_com        <= COM_OFF;
      r_frame_done <= 1'b0;
    end else if (!bus.en) begin
      r_tick       <= '0;
      r_idx        <= '0;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_com        <= COM_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_dp <= DP_OFF;
      if (w_slot_end) begin
        r_tick <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
      if (r_tick == '0 && r_idx == 2'd0) begin
        r_snap[0] <= bus.dig_one;
        r_snap[1] <= bus.dig_ten;
        r_snap[2] <= bus.dig_hun;
      end
      r_frame_done <= w_slot_end && (r_idx == IDX_LAST);
      if (r_tick < TICK_DRIVE) begin
        r_seg <= SEG_OFF;
        r_com <= COM_OFF;
      end else begin
        r_seg <= w_seg_ah ^ SEG_OFF;
        r_com <= w_com_ah ^ COM_OFF;
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.com        = r_com;
  assign bus.frame_done = r_frame_done;

endmodule
